// File: rtl/relay_receive_word_if.sv
// relay_receive_word_if
//   Signal bundle between the relay line synchroniser / framing logic and the
//   oversampling receiver.
//   master : drives data_in, observes the recovered bit/word stream
//   slave  : the receiver (relay_receive_word)
//   Signals: data_in (serial sample), bit_out/bit_valid (decided bit + strobe),
//            data_out/data_valid (assembled word + strobe), receiving (SAMPLE state),
//            parity_err (only when RELAY_RX_PARITY_EN is defined).
interface relay_receive_word_if #(
    parameter int DATA_W = 8
);
    logic              data_in;
    logic              bit_out;
    logic              bit_valid;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              receiving;
`ifdef RELAY_RX_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output data_in,
`ifdef RELAY_RX_PARITY_EN
        input  parity_err,
`endif
        input  bit_out, bit_valid, data_out, data_valid, receiving
    );

    modport slave (
        input  data_in,
`ifdef RELAY_RX_PARITY_EN
        output parity_err,
`endif
        output bit_out, bit_valid, data_out, data_valid, receiving
    );
endinterface

// File: rtl/relay_receive_word.sv
// relay_receive_word
//   Oversampling relay-link receiver. Each bit is decided by strict majority
//   over OVERSAMPLE samples; bits are assembled MSB-first into DATA_W-bit words.
//   Bit timing aligns on the first high sample seen while idle; IDLE_BITS
//   consecutive zero decisions drop back to idle and discard any partial word.
//   Optional feature macro: RELAY_RX_PARITY_EN -- each word is followed by an
//   even-parity bit and rx.parity_err reports the check result.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high
//     rx    : relay_receive_word_if.slave (data_in in; bit_out, bit_valid,
//             data_out, data_valid, receiving [, parity_err] out)
module relay_receive_word #(
    parameter int OVERSAMPLE = 32,
    parameter int DATA_W     = 8,
    parameter int IDLE_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    relay_receive_word_if.slave  rx
);
    localparam int SW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int ZW = $clog2(IDLE_BITS + 1);
`ifdef RELAY_RX_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1;
`else
    localparam int FRAME_BITS = DATA_W;
`endif

    localparam logic [SW-1:0] SMP_LAST   = SW'(OVERSAMPLE);
    localparam logic [SW-1:0] SMP_HALF   = SW'(OVERSAMPLE / 2);
    // Compare the pre-increment count so the frame length never overflows bit_cnt.
    localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_BITS - 1);
    localparam logic [ZW-1:0] ZR_LAST    = ZW'(IDLE_BITS - 1);

    typedef enum logic {IDLE, SAMPLE} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     sample_cnt_q, sample_cnt_d;
    logic [SW-1:0]     one_cnt_q, one_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [ZW-1:0]     zero_run_q, zero_run_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
`ifdef RELAY_RX_PARITY_EN
    logic              parity_err_q, parity_err_d;
`endif

    logic [SW-1:0]     smp_inc, one_inc;
    logic [DATA_W-1:0] shift_nx;
    logic              dec_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            one_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            zero_run_q   <= '0;
            shift_q      <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
`ifdef RELAY_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            one_cnt_q    <= one_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            zero_run_q   <= zero_run_d;
            shift_q      <= shift_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
`ifdef RELAY_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        one_cnt_d    = one_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        zero_run_d   = zero_run_q;
        shift_d      = shift_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
`ifdef RELAY_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        // Counts include the current edge's sample.
        smp_inc  = sample_cnt_q + SW'(1);
        one_inc  = one_cnt_q + SW'(rx.data_in);
        dec_bit  = (one_inc > SMP_HALF);
        shift_nx = {shift_q[DATA_W-2:0], dec_bit};

        case (state_q)
            IDLE: begin
                // The aligning high sample is sample 1 of bit 0.
                if (rx.data_in) begin
                    state_d      = SAMPLE;
                    sample_cnt_d = SW'(1);
                    one_cnt_d    = SW'(1);
                end
            end
            SAMPLE: begin
                sample_cnt_d = smp_inc;
                one_cnt_d    = one_inc;
                if (smp_inc == SMP_LAST) begin
                    bit_out_d    = dec_bit;
                    bit_valid_d  = 1'b1;
                    sample_cnt_d = '0;
                    one_cnt_d    = '0;

                    if (bit_cnt_q == FRAME_LAST) begin
                        bit_cnt_d    = '0;
                        data_valid_d = 1'b1;
`ifdef RELAY_RX_PARITY_EN
                        // Decided bit is the parity bit; the word is already in shift_q.
                        data_out_d   = shift_q;
                        parity_err_d = ^{shift_q, dec_bit};
`else
                        data_out_d   = shift_nx;
                        shift_d      = shift_nx;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shift_d   = shift_nx;
                    end

                    // Idle detection runs after assembly so a word finishing on
                    // the same edge is still delivered.
                    if (dec_bit) begin
                        zero_run_d = '0;
                    end else if (zero_run_q == ZR_LAST) begin
                        state_d    = IDLE;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        zero_run_d = '0;
                    end else begin
                        zero_run_d = zero_run_q + ZW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.bit_out    = bit_out_q;
    assign rx.bit_valid  = bit_valid_q;
    assign rx.data_out   = data_out_q;
    assign rx.data_valid = data_valid_q;
    assign rx.receiving  = (state_q == SAMPLE);
`ifdef RELAY_RX_PARITY_EN
    assign rx.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_relay_receive_word.sv
`timescale 1ns/1ps
module tb_relay_receive_word;
    localparam int OS = 32;
    localparam int DW = 8;
    localparam int IB = 16;
`ifdef RELAY_RX_PARITY_EN
    localparam int FB       = DW + 1;
    localparam int IDLE_IDX = 24;   // 1,0000000,p=1 then 16 zeros: indices 9..24
`else
    localparam int FB       = DW;
    localparam int IDLE_IDX = 16;   // 1 then 16 zeros: indices 1..16
`endif
    localparam int WORD_SMP = OS * FB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    relay_receive_word_if #(.DATA_W(DW)) bus ();

    relay_receive_word #(.OVERSAMPLE(OS), .DATA_W(DW), .IDLE_BITS(IB)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    typedef struct {
        logic [DW-1:0] word;
        logic          perr;
        int            at;
    } exp_w_t;

    exp_w_t wq[$];
    logic   bq[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    exp_w_t m_e;
    logic   m_b;
    logic   prev_dv = 1'b0, prev_bv = 1'b0;
    always @(negedge clk) begin
        if (bus.bit_valid) begin
            check("bit_single", prev_bv, 1'b0);
            check("bit_expected", bq.size() != 0, 1'b1);
            if (bq.size() != 0) begin
                m_b = bq.pop_front();
                check("bit_val", bus.bit_out, m_b);
            end
        end
        if (bus.data_valid) begin
            check("dv_single", prev_dv, 1'b0);
            check("word_expected", wq.size() != 0, 1'b1);
            if (wq.size() != 0) begin
                m_e = wq.pop_front();
                check("word_val", bus.data_out, m_e.word);
                check("word_time", edge_n, m_e.at);
`ifdef RELAY_RX_PARITY_EN
                check("parity_err", bus.parity_err, m_e.perr);
`endif
            end
        end
        prev_dv <= bus.data_valid;
        prev_bv <= bus.bit_valid;
    end

    task automatic smp(input logic v);
        bus.data_in = v;
        @(posedge clk);
        #1;
    endtask

    // mode 0: clean; 1: 15 odd samples inverted; 2: 16 odd samples inverted (tie)
    task automatic send_bit(input logic v, input int mode, input logic expb);
        logic inv;
        bq.push_back(expb);
        for (int i = 0; i < OS; i++) begin
            inv = (mode == 1 && (i % 2) == 1 && i < 30) || (mode == 2 && (i % 2) == 1);
            smp(v ^ inv);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int mode, input int tie_idx,
                             input logic [DW-1:0] expw, input logic pflip);
        exp_w_t e;
        logic   bi, pb;
        int     md;
        pb     = (^w) ^ pflip;
        e.word = expw;
        e.perr = (^expw) ^ pb;
        e.at   = edge_n + WORD_SMP;
        wq.push_back(e);
        for (int i = 0; i < DW; i++) begin
            bi = w[DW-1-i];
            md = (i == tie_idx) ? 2 : mode;
            send_bit(bi, md, (md == 2) ? 1'b0 : bi);
        end
`ifdef RELAY_RX_PARITY_EN
        send_bit(pb, 0, pb);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset       = 1'b1;
        bus.data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) smp(1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"}, bus.data_out, '0);
        check({tag, "_bit_out"}, bus.bit_out, 1'b0);
        check({tag, "_strobes"}, {bus.bit_valid, bus.data_valid}, 2'b00);
        check({tag, "_receiving"}, bus.receiving, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] w0;
        int            s0;
        exp_w_t        e;
        reset       = 1'b1;
        bus.data_in = 1'b0;

        // 1) reset with line toggling, then quiet line
        for (int i = 0; i < 20; i++) begin
            bus.data_in = i[0];
            @(posedge clk);
            #1;
        end
        check_outputs_zero("rst_held");
        reset = 1'b0;
        repeat (100) smp(1'b0);
        check_outputs_zero("rst_quiet");

        // 2) clean A5
        send_word(8'hA5, 0, -1, 8'hA5, 1'b0);
        check("recv_after_word", bus.receiving, 1'b1);
        do_reset();

        // 3) noisy C3, then C3 with a 16/16 tie on bit 1
        send_word(8'hC3, 1, -1, 8'hC3, 1'b0);
        do_reset();
        send_word(8'hC3, 1, 1, 8'h83, 1'b0);
        do_reset();

        // 4) back-to-back words
        send_word(8'h81, 0, -1, 8'h81, 1'b0);
        send_word(8'hFF, 0, -1, 8'hFF, 1'b0);
        do_reset();

        // 5) idle detection after 80, then restart with B1
        s0 = edge_n;
        send_word(8'h80, 0, -1, 8'h80, 1'b0);
        e.word = '0;
        e.perr = 1'b0;
        e.at   = s0 + 2 * WORD_SMP;
        wq.push_back(e);
        for (int b = FB; b < IDLE_IDX; b++) send_bit(1'b0, 0, 1'b0);
        bq.push_back(1'b0);
        repeat (OS - 1) smp(1'b0);
        check("recv_before_idle", bus.receiving, 1'b1);
        smp(1'b0);
        check("recv_at_idle", bus.receiving, 1'b0);
        repeat (50) smp(1'b0);
        check("recv_stays_idle", bus.receiving, 1'b0);
        check("data_hold", bus.data_out, 8'h00);
        send_word(8'hB1, 0, -1, 8'hB1, 1'b0);
        do_reset();

        // 6) async reset mid-cycle after 3 bits of A5
        w0 = 8'hA5;
        for (int i = 0; i < 3; i++) send_bit(w0[DW-1-i], 0, w0[DW-1-i]);
        @(negedge clk);
        #2;
        check("pre_rst_bit_out", bus.bit_out, 1'b1);
        reset = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        bus.data_in = 1'b0;
        reset = 1'b0;
        repeat (10) smp(1'b0);
        send_word(8'hA5, 0, -1, 8'hA5, 1'b0);

`ifdef RELAY_RX_PARITY_EN
        do_reset();
        send_word(8'hA5, 0, -1, 8'hA5, 1'b0);
        do_reset();
        send_word(8'hA5, 0, -1, 8'hA5, 1'b1);
`endif

        repeat (3) smp(1'b0);
        check("word_queue_drained", wq.size(), 0);
        check("bit_queue_drained", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
